// File: rtl/uart_tx_fifo_ctrl.sv
// uart_tx_fifo_ctrl
//
// Transmit-side byte buffer and launcher placed in front of a UART
// transmitter. Host writes land in a circular FIFO; a two-state launcher pops
// one word at a time, hands it to the transmitter with a single-cycle start
// pulse, and waits for the transmitter's done tick before launching the next.
//
// Ports:
//   clk_i           system clock, rising edge
//   rst_i           synchronous active-high reset
//   wr_en_i         host write strobe, one word per cycle
//   wr_data_i       host write data
//   full_o          FIFO holds 2**AddrWidth words
//   empty_o         FIFO holds no words
//   level_o         current word count, 0..2**AddrWidth
//   overflow_o      one-cycle pulse after a write dropped on a full FIFO
//   tx_start_o      one-cycle launch pulse to the transmitter
//   tx_data_o       byte for the transmitter, held until the next launch
//   tx_done_tick_i  one-cycle pulse from the transmitter at end of stop bit
//   busy_o          frame in flight, launch pending, or FIFO non-empty
module uart_tx_fifo_ctrl #(
    parameter int DataWidth = 8,
    parameter int AddrWidth = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 wr_en_i,
    input  logic [DataWidth-1:0] wr_data_i,
    output logic                 full_o,
    output logic                 empty_o,
    output logic [AddrWidth:0]   level_o,
    output logic                 overflow_o,
    output logic                 tx_start_o,
    output logic [DataWidth-1:0] tx_data_o,
    input  logic                 tx_done_tick_i,
    output logic                 busy_o
);

    localparam int Depth = 2 ** AddrWidth;

    typedef enum logic {
        IDLE,
        WAIT_DONE
    } state_t;

    logic [DataWidth-1:0] mem [Depth];

    logic [AddrWidth:0]   wr_ptr_reg;
    logic [AddrWidth:0]   rd_ptr_reg;
    logic [AddrWidth:0]   level_reg;
    state_t               state_reg;
    state_t               state_next;
    logic                 tx_start_reg;
    logic                 tx_start_next;
    logic [DataWidth-1:0] tx_data_reg;
    logic                 overflow_reg;

    logic                 empty;
    logic                 full;
    logic                 wr_accept;
    logic                 pop;

    // Pointers carry one extra wrap bit so that equal addresses can be told
    // apart as empty (same lap) or full (one lap apart). Both flags are pure
    // functions of registered pointers, so a pop this cycle cannot free a
    // slot for a write in the same cycle.
    assign empty     = (wr_ptr_reg == rd_ptr_reg);
    assign full      = (wr_ptr_reg[AddrWidth-1:0] == rd_ptr_reg[AddrWidth-1:0])
                    && (wr_ptr_reg[AddrWidth] != rd_ptr_reg[AddrWidth]);
    assign wr_accept = wr_en_i && !full;

    // Launcher: next state, pop request and start pulse.
    always_comb begin
        state_next    = state_reg;
        tx_start_next = 1'b0;
        pop           = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!empty) begin
                    pop           = 1'b1;
                    tx_start_next = 1'b1;
                    state_next    = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (tx_done_tick_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Storage array: no reset so it maps onto block RAM.
    always_ff @(posedge clk_i) begin
        if (wr_accept) begin
            mem[wr_ptr_reg[AddrWidth-1:0]] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            level_reg    <= '0;
            tx_start_reg <= 1'b0;
            tx_data_reg  <= '0;
            overflow_reg <= 1'b0;
        end else begin
            tx_start_reg <= tx_start_next;
            overflow_reg <= wr_en_i && full;

            if (wr_accept) begin
                wr_ptr_reg <= wr_ptr_reg + (AddrWidth + 1)'(1);
            end

            // Registered read of the head word; it stays on tx_data_o until
            // the next pop overwrites it.
            if (pop) begin
                tx_data_reg <= mem[rd_ptr_reg[AddrWidth-1:0]];
                rd_ptr_reg  <= rd_ptr_reg + (AddrWidth + 1)'(1);
            end

            case ({wr_accept, pop})
                2'b10:   level_reg <= level_reg + (AddrWidth + 1)'(1);
                2'b01:   level_reg <= level_reg - (AddrWidth + 1)'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

    assign full_o     = full;
    assign empty_o    = empty;
    assign level_o    = level_reg;
    assign overflow_o = overflow_reg;
    assign tx_start_o = tx_start_reg;
    assign tx_data_o  = tx_data_reg;
    assign busy_o     = (state_reg != IDLE) || !empty || tx_start_reg;

endmodule

// File: doc/uart_tx_fifo_ctrl.md
Name: uart_tx_fifo_ctrl

Overview:
- Transmit-side buffer and launcher sitting directly upstream of the UART transmitter.
- Accepts bytes from the host/bus side into a circular FIFO.
- Pops one byte at a time into the transmitter with a single-cycle start pulse, then waits for the transmitter's done tick before launching the next byte.
- Decouples bursty host writes from the slow serial bit rate.

Parameters:
- DataWidth, 8, width of each FIFO word and of the byte handed to the transmitter
- AddrWidth, 4, FIFO address width; depth = 2**AddrWidth (16 entries)

Ports:
- clk_i  input  1  system clock, all logic on rising edge
- rst_i  input  1  synchronous active-high reset
- wr_en_i  input  1  host write strobe, one word per cycle
- wr_data_i  input  DataWidth  host write data
- full_o  output  1  FIFO holds 2**AddrWidth words
- empty_o  output  1  FIFO holds 0 words
- level_o  output  AddrWidth+1  current word count, 0..2**AddrWidth
- overflow_o  output  1  one-cycle pulse when a write is dropped because FIFO is full
- tx_start_o  output  1  one-cycle launch pulse to transmitter
- tx_data_o  output  DataWidth  byte for transmitter, valid in the tx_start_o cycle and held until next launch
- tx_done_tick_i  input  1  one-cycle pulse from transmitter at end of stop bit
- busy_o  output  1  high while a frame is in flight or FIFO non-empty

Behaviour:
- One clock (clk_i), synchronous active-high reset (rst_i). All state changes only on the rising edge of clk_i.
- Reset values:
  - Write/read pointers = 0, level_o = 0, empty_o = 1, full_o = 0.
  - overflow_o = 0, tx_start_o = 0, tx_data_o = 0, busy_o = 0.
  - FSM in IDLE.
  - Memory contents are don't-care.
- Pointers:
  - AddrWidth+1 bits each; low AddrWidth bits index memory; wrap naturally modulo 2**(AddrWidth+1).
  - empty when pointers are equal.
  - full when addresses are equal and MSBs differ.
- Write:
  - Accepted when wr_en_i=1 and full_o=0: mem[wr_ptr] <= wr_data_i, wr_ptr += 1.
  - When wr_en_i=1 and full_o=1: data dropped, pointers unchanged, overflow_o=1 for exactly the next cycle.
  - full_o is the registered value; a pop in the same cycle does not make room for that cycle's write.
- level_o:
  - +1 on accepted write only.
  - -1 on pop only.
  - Unchanged when both happen or neither happens.
  - Never exceeds 2**AddrWidth and never underflows.
- FSM, states IDLE and WAIT_DONE:
  - IDLE and empty_o=0: pop (rd_ptr += 1), tx_data_o <= mem[rd_ptr], tx_start_o <= 1, go to WAIT_DONE.
  - IDLE and empty_o=1: tx_start_o <= 0, stay in IDLE.
  - WAIT_DONE: tx_start_o <= 0. On tx_done_tick_i=1 go to IDLE; otherwise stay.
  - tx_done_tick_i in IDLE is ignored.
- Latency:
  - Write into an empty FIFO in cycle N: empty_o falls after edge N; tx_start_o high in cycle N+2.
  - Between frames: tx_done_tick_i in cycle M gives the next tx_start_o in cycle M+2 if the FIFO is non-empty.
- tx_start_o is never high for two consecutive cycles. At most one pop per tx_done_tick_i after the first launch.
- tx_data_o is registered and stable from its tx_start_o cycle until the next launch.
- busy_o = (state != IDLE) or (empty_o = 0) or (tx_start_o = 1).
- Simultaneous write and pop with FIFO at level 1: level stays 1 and the new word is the next head.
- Reset mid-frame: FIFO flushed, FSM back to IDLE, tx_start_o low the cycle after reset. The transmitter shares the reset, so no done tick is expected afterwards.

Test Plan:
- Reset, then idle 10 cycles: empty_o=1, full_o=0, level_o=0, tx_start_o=0, busy_o=0 throughout.
- Write 0xA5 in cycle N, then pulse tx_done_tick_i 20 cycles after the launch:
  - tx_start_o=1 with tx_data_o=0xA5 in cycle N+2 only.
  - level_o returns to 0 after the launch.
  - busy_o falls after the done tick.
- Back-to-back writes 0x01,0x02,0x03 with a done tick 30 cycles after each launch: launches carry 0x01,0x02,0x03 in order, each exactly 2 cycles after the preceding done tick.
- Hold the transmitter (no done tick) and write 17 words 0x00..0x10:
  - First word launches, so 16 are stored; full_o=1.
  - A further write pulses overflow_o once and does not change level_o=16.
- With level_o=1 and the FSM in IDLE, write 0x5A in the same cycle as the pop: level_o stays 1 and the next launch after the done tick carries 0x5A.
- Assert rst_i for 1 cycle while in WAIT_DONE with level_o=5: level_o=0, empty_o=1, no tx_start_o until a new write arrives.
